bcd_conv_arbiter: RTL and testbench

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_conv_arbiter_dd_step.sv | 25 ++
 rtl/bcd_conv_arbiter.sv | 138 +++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types for the two-channel BCD converter.
// FSM states, default widths, BCD word and channel index.
package bcd_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [15:0] bcd_t;
  typedef logic        ch_t;

  localparam ch_t CH0 = 1'b0;
  localparam ch_t CH1 = 1'b1;

endpackage

// File: rtl/bcd_conv_arbiter_dd_step.sv
// One double-dabble iteration: add 3 to digits >= 5, shift left.
// sr_in/sr_out: {digits, binary} shift register, combinational.
module bcd_dd_step #(
  parameter int DATA_W = 12,
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4+DATA_W-1:0] sr_in,
  output logic [DIGITS*4+DATA_W-1:0] sr_out
);

  localparam int SR_W = DIGITS*4 + DATA_W;

  logic [SR_W-1:0] adj;

  always_comb begin
    adj = sr_in;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_in[DATA_W+4*k +: 4] >= 4'd5) begin
        adj[DATA_W+4*k +: 4] = sr_in[DATA_W+4*k +: 4] + 4'd3;
      end
    end
    sr_out = {adj[SR_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Two-channel binary-to-BCD converter sharing one engine.
// req/data/ack/bcd per channel, display digit mux, busy.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [15:0]       bcd0,
  output logic [15:0]       bcd1,
  input  logic              average_enable,
  output logic [3:0]        ones,
  output logic [3:0]        tens,
  output logic [3:0]        hundreds,
  output logic [3:0]        thousands,
  output logic              busy
);

  localparam int SR_W = DIGITS*4 + DATA_W;
  localparam logic [3:0] LAST_IT = 4'(DATA_W-1);

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr, sr_step;
  logic [3:0]        cnt;
  ch_t               ch, rr;
  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] last0, last1;
  logic              valid0, valid1;

  logic              gnt_any;
  ch_t               gnt_ch;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_skip;

  bcd_dd_step #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_step (
    .sr_in  (sr),
    .sr_out (sr_step)
  );

  always_comb begin
    gnt_any = req0 | req1;
    gnt_ch  = CH0;
    unique case (1'b1)
      (req0 && req1):  gnt_ch = rr;
      (req1 && !req0): gnt_ch = CH1;
      default:         gnt_ch = CH0;
    endcase
    gnt_data = gnt_ch ? data1 : data0;
    // Same value as the last finished conversion: reuse it.
    gnt_skip = gnt_ch ? (valid1 && data1 == last1)
                      : (valid0 && data0 == last0);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_any) state_nx = gnt_skip ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST_IT) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      ch        <= CH0;
      rr        <= CH0;
      val_q     <= '0;
      last0     <= '0;
      last1     <= '0;
      valid0    <= 1'b0;
      valid1    <= 1'b0;
      bcd0      <= '0;
      bcd1      <= '0;
      thousands <= '0;
      hundreds  <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      state <= state_nx;
      {thousands, hundreds, tens, ones}
        <= average_enable ? bcd1 : bcd0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            sr    <= {{(DIGITS*4){1'b0}}, gnt_data};
            cnt   <= '0;
            ch    <= gnt_ch;
            val_q <= gnt_data;
          end
        end
        SHIFT: begin
          sr  <= sr_step;
          cnt <= cnt + 4'd1;
          if (cnt == LAST_IT) begin
            if (ch) begin
              bcd1   <= sr_step[SR_W-1 -: 16];
              last1  <= val_q;
              valid1 <= 1'b1;
            end else begin
              bcd0   <= sr_step[SR_W-1 -: 16];
              last0  <= val_q;
              valid0 <= 1'b1;
            end
          end
        end
        DONE: begin
          rr  <= ~ch;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ack0 = (state == DONE) && (ch == CH0);
  assign ack1 = (state == DONE) && (ch == CH1);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter.
// Directed scenarios plus a cycle-level reference model.
module tb_bcd_conv_arbiter;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1;
  logic [15:0]   bcd0, bcd1;
  logic          average_enable;
  logic [3:0]    ones, tens, hundreds, thousands;
  logic          busy;

  bcd_conv_arbiter #(.DATA_W(DW), .DIGITS(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0           (req0),
    .req1           (req1),
    .data0          (data0),
    .data1          (data1),
    .ack0           (ack0),
    .ack1           (ack1),
    .bcd0           (bcd0),
    .bcd1           (bcd1),
    .average_enable (average_enable),
    .ones           (ones),
    .tens           (tens),
    .hundreds       (hundreds),
    .thousands      (thousands),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: a conversion is a job that acks DW edges after
  // its grant (0 edges when the value repeats), then frees one edge later.
  int          k = 0;
  bit          m_active;
  int          m_ack_at;
  bit          m_ch, m_rr, m_skip;
  int          m_val;
  logic [15:0] m_bcd [2];
  int          m_last [2];
  bit          m_valid [2];
  logic [15:0] m_disp;
  bit          m_ack0, m_ack1;

  always @(posedge clk) begin
    k++;
    if (!rst_n) begin
      m_active = 0; m_rr = 0; m_ch = 0; m_skip = 0;
      m_bcd[0] = 0; m_bcd[1] = 0;
      m_last[0] = 0; m_last[1] = 0;
      m_valid[0] = 0; m_valid[1] = 0;
      m_disp = 0; m_ack0 = 0; m_ack1 = 0;
    end else begin
      bit ack_now;
      m_disp = average_enable ? m_bcd[1] : m_bcd[0];
      ack_now = 0;
      if (m_active) begin
        if (k == m_ack_at + 1) begin
          m_active = 0;
          m_rr = !m_ch;
        end else if (k == m_ack_at) begin
          if (!m_skip) begin
            m_bcd[m_ch] = to_bcd(m_val);
            m_last[m_ch] = m_val;
            m_valid[m_ch] = 1;
          end
          ack_now = 1;
        end
      end else if (req0 || req1) begin
        m_ch = (req0 && req1) ? m_rr : req1;
        m_val = m_ch ? int'(data1) : int'(data0);
        m_skip = m_valid[m_ch] && (m_last[m_ch] == m_val);
        m_active = 1;
        m_ack_at = m_skip ? k : k + DW;
        ack_now = m_skip;
      end
      m_ack0 = ack_now && !m_ch;
      m_ack1 = ack_now && m_ch;
    end
  end

  task automatic wait_any(input int limit, output int which, output int n);
    which = -1;
    n = 0;
    while (which < 0 && n < limit) begin
      @(negedge clk);
      n++;
      if (ack0) which = 0;
      else if (ack1) which = 1;
    end
    if (which < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: no ack within %0d cycles at %0t", limit, $time);
    end
  endtask

  initial begin
    int w, n, t2, t3;
    int order [3];
    rst_n = 0; req0 = 0; req1 = 0;
    data0 = '0; data1 = '0; average_enable = 0;

    fork
      forever begin
        @(negedge clk);
        if (k > 0) begin
          chk("m_ack0", {31'd0, ack0}, {31'd0, m_ack0});
          chk("m_ack1", {31'd0, ack1}, {31'd0, m_ack1});
          chk("m_busy", {31'd0, busy}, {31'd0, m_active});
          chk("m_bcd0", {16'd0, bcd0}, {16'd0, m_bcd[0]});
          chk("m_bcd1", {16'd0, bcd1}, {16'd0, m_bcd[1]});
          chk("m_disp", {16'd0, thousands, hundreds, tens, ones},
              {16'd0, m_disp});
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bcd0", {16'd0, bcd0}, 32'd0);
    chk("rst_bcd1", {16'd0, bcd1}, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // First request of value 0: no skip, full conversion.
    req0 = 1; data0 = 12'd0;
    wait_any(40, w, n);
    req0 = 0;
    chk("zero_ch", w, 32'd0);
    chk("zero_lat", n, DW + 1);
    chk("zero_bcd0", {16'd0, bcd0}, 32'h0);
    repeat (2) @(negedge clk);

    // Full scale.
    req0 = 1; data0 = 12'd4095;
    wait_any(40, w, n);
    req0 = 0;
    chk("max_lat", n, DW + 1);
    chk("max_bcd0", {16'd0, bcd0}, 32'h4095);
    chk("max_model", {16'd0, m_bcd[0]}, 32'h4095);
    @(negedge clk);
    chk("max_thou", {28'd0, thousands}, 32'd4);
    @(negedge clk);

    // Dual contention after reset.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0 = 1; req1 = 1; data0 = 12'd1234; data1 = 12'd567;
    t2 = 0; t3 = 0;
    for (int i = 0; i < 3; i++) begin
      wait_any(40, w, n);
      order[i] = w;
      if (i == 2) t3 = n;
    end
    req0 = 0; req1 = 0;
    chk("dual_o0", order[0], 32'd0);
    chk("dual_o1", order[1], 32'd1);
    chk("dual_o2", order[2], 32'd0);
    chk("dual_skip_gap", t3, 32'd2);
    chk("dual_bcd0", {16'd0, bcd0}, 32'h1234);
    chk("dual_bcd1", {16'd0, bcd1}, 32'h0567);
    repeat (2) @(negedge clk);

    // Display select.
    req0 = 1; data0 = 12'd42;
    wait_any(40, w, n);
    req0 = 0;
    @(negedge clk);
    req1 = 1; data1 = 12'd3000;
    wait_any(40, w, n);
    req1 = 0;
    repeat (2) @(negedge clk);
    average_enable = 1;
    #1;
    chk("disp_before", {16'd0, thousands, hundreds, tens, ones}, 32'h0042);
    @(negedge clk);
    chk("disp_after", {16'd0, thousands, hundreds, tens, ones}, 32'h3000);

    // Inputs changing after grant are ignored.
    req1 = 1; data1 = 12'd999;
    @(posedge clk);
    #1;
    req1 = 0; data1 = 12'd0;
    wait_any(40, w, n);
    chk("late_ch", w, 32'd1);
    chk("late_bcd1", {16'd0, bcd1}, 32'h0999);
    repeat (2) @(negedge clk);

    // Reset during iteration 6 of a ch0 conversion.
    req0 = 1; data0 = 12'd4000;
    @(negedge clk);
    req0 = 0;
    repeat (6) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bcd0", {16'd0, bcd0}, 32'd0);
    repeat (15) @(negedge clk);
    req0 = 1; req1 = 1; data0 = 12'd5; data1 = 12'd6;
    wait_any(40, w, n);
    req0 = 0; req1 = 0;
    chk("abort_next_ch", w, 32'd0);
    chk("abort_next_bcd0", {16'd0, bcd0}, 32'h0005);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
